// File: rtl/spi_norflash_model_if.sv
// spi_norflash_model_if: 32-bit framed SPI bus between the NOR flash controller (master) and the flash (slave).
interface spi_norflash_model_if #(parameter int LINEWIDE = 32);
    logic                s_clk;
    logic                s_css;
    logic [LINEWIDE-1:0] s_mosi;
    logic [LINEWIDE-1:0] s_miso;
    modport master (output s_clk, s_css, s_mosi, input s_miso);
    modport slave  (input s_clk, s_css, s_mosi, output s_miso);
endinterface

// File: rtl/spi_norflash_model.sv
// spi_norflash_model: oversampled SPI NOR flash responder with program/erase busy timing and write-enable latch.
// Define NORFLASH_WEL_CHECK_EN to make PROGRAM/ERASE require WEL=1.
module spi_norflash_model #(
    parameter int LINEWIDE     = 32,
    parameter int DEPTH        = 16,
    parameter int PROG_CYCLES  = 8,
    parameter int ERASE_CYCLES = 32
) (
    input logic                 p_clk,
    input logic                 p_rst_n,
    spi_norflash_model_if.slave spi
);
    localparam int IW   = $clog2(DEPTH);
    localparam int MAXC = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [7:0] C_READ = 8'h01, C_PROG = 8'h02, C_RDSR = 8'h05, C_WREN = 8'h06, C_ERASE = 8'h20;
    logic [1:0]          r_sclk_s, r_css_s, r_beat;
    logic                r_sclk_d, r_wel, r_busy;
    logic [7:0]          r_cmd;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic [LINEWIDE-1:0] r_miso;
    logic [LINEWIDE-1:0] r_mem [DEPTH];
    logic                w_css, w_fire, w_b1, w_b2, w_wel_ok, w_ok, w_erase, w_prog;
    logic [7:0]          w_op;
    logic [IW-1:0]       w_idx;
    logic [LINEWIDE-1:0] w_status;
`ifdef NORFLASH_WEL_CHECK_EN
    assign w_wel_ok = r_wel;
`else
    assign w_wel_ok = 1'b1;
`endif
    assign w_css    = r_css_s[1];
    assign w_fire   = r_sclk_s[1] & ~r_sclk_d & ~w_css;
    assign w_b1     = w_fire && r_beat == 2'd0;
    assign w_b2     = w_fire && r_beat == 2'd1;
    assign w_op     = spi.s_mosi[7:0];
    assign w_idx    = spi.s_mosi[8 +: IW];
    assign w_ok     = w_wel_ok & ~r_busy;
    assign w_erase  = w_b1 && w_op == C_ERASE && w_ok;
    assign w_prog   = w_b2 && r_cmd == C_PROG && w_ok;
    assign w_status = {{(LINEWIDE-2){1'b0}}, r_wel, r_busy};
    assign spi.s_miso = r_miso;
    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            r_sclk_s <= '0;
            r_css_s  <= '1;
            r_sclk_d <= 1'b0;
            r_beat   <= '0;
            r_cmd    <= '0;
            r_idx    <= '0;
        end else begin
            r_sclk_s <= {r_sclk_s[0], spi.s_clk};
            r_css_s  <= {r_css_s[0], spi.s_css};
            r_sclk_d <= r_sclk_s[1];
            r_beat   <= w_css ? 2'd0 : (w_fire && r_beat != 2'd3) ? r_beat + 2'd1 : r_beat;
            if (w_b1) begin
                r_cmd <= w_op;
                r_idx <= w_idx;
            end
        end
    end
    // BUSY drops on the same edge the down-counter reaches zero
    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            r_wel  <= 1'b0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_erase || w_prog)
                r_wel <= 1'b0;
            else if (w_b1 && w_op == C_WREN && !r_busy)
                r_wel <= 1'b1;
            if (w_erase || w_prog) begin
                r_busy <= 1'b1;
                r_cnt  <= w_erase ? CW'(ERASE_CYCLES) : CW'(PROG_CYCLES);
            end else if (r_busy) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1))
                    r_busy <= 1'b0;
            end
        end
    end
    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n)
            r_miso <= '0;
        else if (w_b1) begin
            if (w_op == C_READ && !r_busy)
                r_miso <= r_mem[w_idx];
            else if (w_op == C_RDSR)
                r_miso <= w_status;
        end else if (r_cmd == C_RDSR && !w_css)
            r_miso <= w_status;
    end
    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '1;
        end else if (w_erase)
            r_mem[w_idx] <= '1;
        else if (w_prog)
            r_mem[r_idx] <= r_mem[r_idx] & spi.s_mosi;
    end
endmodule

// File: tb/tb_spi_norflash_model.sv
// tb_spi_norflash_model: directed frame table plus hand sequences for erase polling and reset mid-program.
module tb_spi_norflash_model;
    localparam logic [7:0] C_READ = 8'h01, C_PROG = 8'h02, C_RDSR = 8'h05, C_WREN = 8'h06, C_ERASE = 8'h20;
    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] idx;
        logic [31:0] data;
        int          nb;
        int          wt;
        bit          chk;
        logic [31:0] exp;
    } vec_t;
    logic p_clk = 1'b0;
    logic p_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    spi_norflash_model_if #(.LINEWIDE(32)) bus ();
    spi_norflash_model #(.LINEWIDE(32), .DEPTH(16), .PROG_CYCLES(8), .ERASE_CYCLES(32)) dut (
        .p_clk   (p_clk),
        .p_rst_n (p_rst_n),
        .spi     (bus.slave)
    );
    always #5 p_clk = ~p_clk;
    task automatic cyc(input int n);
        repeat (n) @(negedge p_clk);
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask
    task automatic beat(input logic [31:0] w);
        bus.s_mosi = w;
        cyc(2);
        bus.s_clk = 1'b1;
        cyc(5);
        bus.s_clk = 1'b0;
        cyc(5);
    endtask
    task automatic frame(input logic [7:0] cmd, input logic [23:0] idx, input logic [31:0] data, input int nb);
        bus.s_css = 1'b0;
        cyc(2);
        for (int b = 0; b < nb; b++)
            beat(b == 0 ? {idx, cmd} : data);
        bus.s_css = 1'b1;
        cyc(6);
    endtask
    vec_t v [21];
    logic [31:0] w_nowel;
    int n_busy;
    bit done;
    initial begin
`ifdef NORFLASH_WEL_CHECK_EN
        w_nowel = 32'hFFFF_FFFF;
`else
        w_nowel = 32'h0000_0000;
`endif
        v[0]  = '{C_READ,  24'd0,  32'h0,         1, 0,  1'b1, 32'hFFFF_FFFF};
        v[1]  = '{C_RDSR,  24'd0,  32'h0,         1, 0,  1'b1, 32'h0};
        v[2]  = '{C_WREN,  24'd0,  32'h0,         1, 0,  1'b0, 32'h0};
        v[3]  = '{C_RDSR,  24'd0,  32'h0,         1, 0,  1'b1, 32'h2};
        v[4]  = '{C_PROG,  24'd0,  32'hFF00_FF00, 2, 10, 1'b0, 32'h0};
        v[5]  = '{C_READ,  24'd0,  32'h0,         1, 0,  1'b1, 32'hFF00_FF00};
        v[6]  = '{C_RDSR,  24'd0,  32'h0,         1, 0,  1'b1, 32'h0};
        v[7]  = '{C_PROG,  24'd1,  32'h0,         2, 10, 1'b0, 32'h0};
        v[8]  = '{C_READ,  24'd1,  32'h0,         1, 0,  1'b1, w_nowel};
        v[9]  = '{C_WREN,  24'd0,  32'h0,         1, 0,  1'b0, 32'h0};
        v[10] = '{C_PROG,  24'd0,  32'h0F0F_0F0F, 2, 10, 1'b0, 32'h0};
        v[11] = '{C_READ,  24'd0,  32'h0,         1, 0,  1'b1, 32'h0F00_0F00};
        v[12] = '{C_WREN,  24'd0,  32'h0,         1, 0,  1'b0, 32'h0};
        v[13] = '{C_PROG,  24'd2,  32'h0,         1, 0,  1'b0, 32'h0};
        v[14] = '{C_RDSR,  24'd0,  32'h0,         1, 0,  1'b1, 32'h2};
        v[15] = '{C_READ,  24'd2,  32'h0,         1, 0,  1'b1, 32'hFFFF_FFFF};
        v[16] = '{C_READ,  24'd16, 32'h0,         1, 0,  1'b1, 32'h0F00_0F00};
        v[17] = '{8'h77,   24'd0,  32'h0,         1, 0,  1'b1, 32'h0F00_0F00};
        v[18] = '{C_WREN,  24'd0,  32'h0,         1, 0,  1'b0, 32'h0};
        v[19] = '{C_PROG,  24'd18, 32'h0,         2, 10, 1'b0, 32'h0};
        v[20] = '{C_READ,  24'd2,  32'h0,         1, 0,  1'b1, 32'h0};
        bus.s_clk = 1'b0;
        bus.s_css = 1'b1;
        bus.s_mosi = '0;
        cyc(3);
        check("reset_miso", bus.s_miso, 32'h0);
        p_rst_n = 1'b1;
        cyc(3);
        for (int i = 0; i < 21; i++) begin
            frame(v[i].cmd, v[i].idx, v[i].data, v[i].nb);
            cyc(v[i].wt);
            if (v[i].chk)
                check($sformatf("vec%0d", i), bus.s_miso, v[i].exp);
        end
        // erase then poll status inside one long RDSR frame
        frame(C_WREN, 24'd0, 32'h0, 1);
        frame(C_ERASE, 24'd0, 32'h0, 1);
        bus.s_css = 1'b0;
        cyc(2);
        bus.s_mosi = {24'd0, C_RDSR};
        cyc(2);
        bus.s_clk = 1'b1;
        cyc(5);
        check("erase_busy", bus.s_miso, 32'h1);
        n_busy = 0;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            if (bus.s_miso == 32'h0)
                done = 1'b1;
            else begin
                n_busy++;
                cyc(1);
            end
        end
        check("erase_done", bus.s_miso, 32'h0);
        check("erase_len_ok", 32'(n_busy > 0 && n_busy < 32), 32'h1);
        bus.s_clk = 1'b0;
        cyc(3);
        bus.s_css = 1'b1;
        cyc(6);
        frame(C_READ, 24'd0, 32'h0, 1);
        check("erase_read", bus.s_miso, 32'hFFFF_FFFF);
        // reset while a program is busy
        frame(C_WREN, 24'd0, 32'h0, 1);
        bus.s_css = 1'b0;
        cyc(2);
        beat({24'd0, C_PROG});
        bus.s_mosi = 32'h0;
        cyc(2);
        bus.s_clk = 1'b1;
        cyc(5);
        check("prog_hold_miso", bus.s_miso, 32'hFFFF_FFFF);
        p_rst_n = 1'b0;
        #1;
        check("rst_async_miso", bus.s_miso, 32'h0);
        cyc(2);
        bus.s_clk = 1'b0;
        bus.s_css = 1'b1;
        p_rst_n = 1'b1;
        cyc(4);
        frame(C_RDSR, 24'd0, 32'h0, 1);
        check("rst_status", bus.s_miso, 32'h0);
        frame(C_READ, 24'd0, 32'h0, 1);
        check("rst_read0", bus.s_miso, 32'hFFFF_FFFF);
        frame(C_READ, 24'd2, 32'h0, 1);
        check("rst_read2", bus.s_miso, 32'hFFFF_FFFF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
